nw_traceback: RTL
=================

Name: nw_traceback

Overview:
Traceback engine for the Needleman-Wunsch pipeline; it is the reader side of the direction memory that the fill stage (grid of scoring cells) writes. After the fill completes, it walks from cell (len1,len2) back to (0,0), reading one 2-bit direction per interior cell. It emits the alignment as a stream of edit operations, last operation first, over a valid/ready handshake.

Parameters:
LENGTH, 10, max characters per string; the direction memory holds LENGTH*LENGTH entries
IWIDTH, 4, bits for lengths and row/column indices; requires 2^IWIDTH > LENGTH
AWIDTH, 8, direction-memory address bits; requires LENGTH*LENGTH <= 2^AWIDTH

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin traceback; sampled only in IDLE
len1  in  IWIDTH  length of s1 (rows, index i)
len2  in  IWIDTH  length of s2 (columns, index j)
dir_rd_en  out  1  direction-memory read strobe
dir_addr  out  AWIDTH  read address = (i-1)*LENGTH + (j-1), for i,j >= 1
dir_data  in  2  read data, valid exactly 1 cycle after dir_rd_en
op_valid  out  1  operation available
op_ready  in  1  consumer accepts the operation
op  out  2  00 DIAG (match/mismatch, i--,j--); 01 UP (gap in s2, i--); 10 LEFT (gap in s1, j--)
op_last  out  1  qualifies the final operation, which reaches (0,0)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of traceback or error
err  out  1  sticky error flag; cleared when the next start is accepted

Behaviour:
- Reset: state IDLE. dir_rd_en, op_valid, op, op_last, busy, done and err are all 0. dir_addr is 0. i and j are 0.
- Reset mid-operation abandons the traceback. All outputs reach their reset values the cycle after rst is sampled. No done pulse is produced.
- States: IDLE, READ, WAIT, EMIT, DONE, ERR.
- IDLE, start=1:
  - Clear err and load i=len1, j=len2.
  - If len1>LENGTH or len2>LENGTH: go to ERR.
  - Else if len1=0 and len2=0: go to DONE; no operations are emitted.
  - Else if i>0 and j>0: go to READ.
  - Else: go to EMIT with a boundary operation (LEFT if i=0, UP if j=0).
- start while busy is ignored.
- READ: dir_rd_en=1 for exactly one cycle with dir_addr for the current (i,j), then go to WAIT.
- WAIT: register dir_data.
  - Value 11 is invalid: go to ERR and emit no operation.
  - Otherwise go to EMIT.
- EMIT: op_valid=1.
  - op_last=1 iff applying op yields i=0 and j=0.
  - op and op_last are held stable while op_valid=1 and op_ready=0.
  - On op_valid and op_ready, apply the move to i and j. If last, go to DONE. Else go to READ if i>0 and j>0; otherwise stay in EMIT with the next boundary op.
- op_valid rises only after the registered state update, never combinationally from op_ready.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: err=1 and done=1 for one cycle, then go to IDLE. err stays 1 until the next accepted start.
- Throughput with op_ready held high:
  - interior cell: 3 cycles per op (READ, WAIT, EMIT);
  - boundary op: 1 cycle per op.
- A direction that moves i or j below 0 cannot occur for interior cells, because interior cells are only read when i,j >= 1.
- Ops emitted per run = len1 + len2 - (number of DIAG ops).
- dir_addr is driven from registered i and j; no combinational path exists from inputs to outputs.

Test Plan:
- LENGTH=4, len1=len2=2, memory all DIAG -> reads at addr 5 then 0; ops DIAG, DIAG with op_last on the 2nd; done one cycle after the final handshake; err=0.
- LENGTH=4, len1=3, len2=1, dir[8]=UP, dir[4]=UP, dir[0]=DIAG -> reads 8, 4, 0; ops UP, UP, DIAG; op_last only on DIAG.
- len1=0, len2=3 -> dir_rd_en never asserted; ops LEFT, LEFT, LEFT on 3 consecutive cycles with op_ready=1; op_last on the 3rd. Separately, len1=len2=0 -> done pulses with no ops.
- Backpressure: in scenario 2, hold op_ready=0 for 5 cycles on the 2nd op -> op_valid stays 1 and op=01 is stable; no new read is issued; the sequence completes unchanged once ready rises. Also pulse start mid-run -> it is ignored.
- Error: dir[5]=11 with len1=len2=2 -> no ops; err=1 and done pulse; a later good start clears err. Also len1=5 with LENGTH=4 -> err, no memory reads.
- Assert rst during the WAIT of scenario 1 -> next cycle all outputs are 0 and busy=0; a fresh start reruns correctly.

Source files
------------

// File: rtl/nw_traceback_if.sv
// Handshake and memory-read bundle between the traceback engine and its environment.
// The slave modport is the engine's view; the master modport is the driver/consumer side.
interface nw_traceback_if #(
    parameter int IWIDTH = 4,
    parameter int AWIDTH = 8
);
    logic              start;
    logic [IWIDTH-1:0] len1;
    logic [IWIDTH-1:0] len2;
    logic              dir_rd_en;
    logic [AWIDTH-1:0] dir_addr;
    logic [1:0]        dir_data;
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op;
    logic              op_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, len1, len2, dir_data, op_ready,
        input  dir_rd_en, dir_addr, op_valid, op, op_last, busy, done, err
    );

    modport slave (
        input  start, len1, len2, dir_data, op_ready,
        output dir_rd_en, dir_addr, op_valid, op, op_last, busy, done, err
    );
endinterface

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the direction memory from (len1,len2) back to (0,0)
// and streams edit operations, last operation first, over a valid/ready handshake.
module nw_traceback #(
    parameter int LENGTH = 10,
    parameter int IWIDTH = 4,
    parameter int AWIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    nw_traceback_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [1:0] OP_DIAG = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_LEFT = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IWIDTH-1:0] r_i;
    logic [IWIDTH-1:0] r_j;
    logic [IWIDTH-1:0] w_i_mv;
    logic [IWIDTH-1:0] w_j_mv;
    logic [1:0]        r_op;
    logic              r_op_last;
    logic              r_err;
    logic              w_len_bad;
    logic [AWIDTH-1:0] w_addr;

    // True when applying op at (i,j) lands exactly on the origin.
    function automatic logic is_last(input logic [1:0] op, input logic [IWIDTH-1:0] i,
                                     input logic [IWIDTH-1:0] j);
        logic res;
        case (op)
            OP_DIAG: res = (i == IWIDTH'(1)) && (j == IWIDTH'(1));
            OP_UP:   res = (i == IWIDTH'(1)) && (j == IWIDTH'(0));
            OP_LEFT: res = (i == IWIDTH'(0)) && (j == IWIDTH'(1));
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // On an edge of the grid only one move is possible.
    function automatic logic [1:0] bnd_op(input logic [IWIDTH-1:0] i);
        return (i == IWIDTH'(0)) ? OP_LEFT : OP_UP;
    endfunction

    // Coordinates after applying the pending op, and length/address decode.
    always_comb begin
        w_i_mv = r_i;
        w_j_mv = r_j;
        case (r_op)
            OP_DIAG: begin
                w_i_mv = r_i - IWIDTH'(1);
                w_j_mv = r_j - IWIDTH'(1);
            end
            OP_UP:   w_i_mv = r_i - IWIDTH'(1);
            OP_LEFT: w_j_mv = r_j - IWIDTH'(1);
            default: begin
                w_i_mv = r_i;
                w_j_mv = r_j;
            end
        endcase
        w_len_bad = (bus.len1 > IWIDTH'(LENGTH)) || (bus.len2 > IWIDTH'(LENGTH));
        w_addr    = (AWIDTH'(r_i) - AWIDTH'(1)) * AWIDTH'(LENGTH) + AWIDTH'(r_j) - AWIDTH'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!bus.start) begin
                    w_state_nxt = S_IDLE;
                end else if (w_len_bad) begin
                    w_state_nxt = S_ERR;
                end else if ((bus.len1 == IWIDTH'(0)) && (bus.len2 == IWIDTH'(0))) begin
                    w_state_nxt = S_DONE;
                end else if ((bus.len1 != IWIDTH'(0)) && (bus.len2 != IWIDTH'(0))) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_READ: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.dir_data == OP_BAD) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!bus.op_ready) begin
                    w_state_nxt = S_EMIT;
                end else if (r_op_last) begin
                    w_state_nxt = S_DONE;
                end else if ((w_i_mv != IWIDTH'(0)) && (w_j_mv != IWIDTH'(0))) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Coordinates, pending op and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i       <= IWIDTH'(0);
            r_j       <= IWIDTH'(0);
            r_op      <= OP_DIAG;
            r_op_last <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_i       <= bus.len1;
                        r_j       <= bus.len2;
                        r_err     <= w_len_bad;
                        r_op      <= bnd_op(bus.len1);
                        r_op_last <= is_last(bnd_op(bus.len1), bus.len1, bus.len2);
                    end
                end
                S_WAIT: begin
                    r_op      <= bus.dir_data;
                    r_op_last <= is_last(bus.dir_data, r_i, r_j);
                    r_err     <= r_err | (bus.dir_data == OP_BAD);
                end
                S_EMIT: begin
                    if (bus.op_ready) begin
                        r_i       <= w_i_mv;
                        r_j       <= w_j_mv;
                        r_op      <= bnd_op(w_i_mv);
                        r_op_last <= is_last(bnd_op(w_i_mv), w_i_mv, w_j_mv);
                    end
                end
                default: begin
                    r_op <= r_op;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        bus.dir_rd_en = (r_state == S_READ);
        bus.dir_addr  = (r_state == S_READ) ? w_addr : AWIDTH'(0);
        bus.op_valid  = (r_state == S_EMIT);
        bus.op        = r_op;
        bus.op_last   = r_op_last & (r_state == S_EMIT);
        bus.busy      = (r_state != S_IDLE);
        bus.done      = (r_state == S_DONE) || (r_state == S_ERR);
        bus.err       = r_err;
    end
endmodule
